// File: rtl/alu_dec_pkg.sv
// alu_dec_pkg: ALU operation codes, opcodes, operand selects and immediate formats for the decode stage
package alu_dec_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [1:0] ASEL_RS1  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH} imm_fmt_e;
    // base operation selected by funct3 when funct7 carries no modifier
    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        return f3 == 3'd0 ? ALU_ADD  : f3 == 3'd1 ? ALU_SLL : f3 == 3'd2 ? ALU_SLT :
               f3 == 3'd3 ? ALU_SLTU : f3 == 3'd4 ? ALU_XOR : f3 == 3'd5 ? ALU_SRL :
               f3 == 3'd6 ? ALU_OR   : ALU_AND;
    endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: extracts the sign-extended immediate of the selected instruction format
module imm_gen
    import alu_dec_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);
    always_comb
        imm = fmt == IMM_I  ? {{20{instr[31]}}, instr[31:20]} :
              fmt == IMM_S  ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
              fmt == IMM_B  ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
              fmt == IMM_U  ? {instr[31:12], 12'h000} :
              fmt == IMM_J  ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
              fmt == IMM_SH ? {27'd0, instr[24:20]} : 32'd0;
endmodule

// File: rtl/alu_dec.sv
// alu_dec: registered RV32I decode stage producing ALU control and operand selects over valid/ready
module alu_dec
    import alu_dec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alusel,
    output logic [1:0]      out_asel,
    output logic            out_bsel,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_regwen,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] alusel;
    logic [1:0] asel;
    logic bsel, regwen, ill, accept;
    imm_fmt_e fmt;
    logic [31:0] imm;
    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];
    assign in_ready = !out_valid || out_ready || flush;
    assign accept = in_valid && in_ready && !flush;
    imm_gen u_imm (.instr(in_instr), .fmt(fmt), .imm(imm));
    always_comb begin
        alusel = ALU_ADD;
        asel = ASEL_RS1;
        bsel = 1'b0;
        fmt = IMM_NONE;
        regwen = 1'b0;
        ill = 1'b0;
        case (op)
            OPC_OP: begin
                regwen = 1'b1;
                alusel = f7 == 7'h00 ? f3_alu(f3) : f3 == 3'd0 ? ALU_SUB : ALU_SRA;
                ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            OPC_OPIMM: begin
                regwen = 1'b1;
                bsel = 1'b1;
                fmt = (f3 == 3'd1 || f3 == 3'd5) ? IMM_SH : IMM_I;
                alusel = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : f3_alu(f3);
                ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            OPC_LUI:    begin asel = ASEL_ZERO; bsel = 1'b1; fmt = IMM_U; regwen = 1'b1; end
            OPC_AUIPC:  begin asel = ASEL_PC; bsel = 1'b1; fmt = IMM_U; regwen = 1'b1; end
            OPC_LOAD:   begin bsel = 1'b1; fmt = IMM_I; regwen = 1'b1; end
            OPC_STORE:  begin bsel = 1'b1; fmt = IMM_S; end
            OPC_BRANCH: begin asel = ASEL_PC; bsel = 1'b1; fmt = IMM_B; end
            OPC_JAL:    begin asel = ASEL_PC; bsel = 1'b1; fmt = IMM_J; regwen = 1'b1; end
            OPC_JALR:   begin bsel = 1'b1; fmt = IMM_I; regwen = 1'b1; ill = f3 != 3'd0; end
            OPC_MISC:   ill = 1'b0;
            default:    ill = 1'b1;
        endcase
        // an illegal bundle carries a neutral ADD of rs1 and rs2 with no writeback
        if (ill) begin
            alusel = ALU_ADD;
            asel = ASEL_RS1;
            bsel = 1'b0;
            fmt = IMM_NONE;
            regwen = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            out_valid <= 1'b0;
        else
            out_valid <= flush ? 1'b0 : accept ? 1'b1 : out_valid && !out_ready;
        if (rst) begin
            out_alusel <= ALU_ADD;
            out_asel <= ASEL_RS1;
            out_bsel <= 1'b0;
            out_imm <= '0;
            out_rs1 <= '0;
            out_rs2 <= '0;
            out_rd <= '0;
            out_regwen <= 1'b0;
            out_illegal <= 1'b0;
            out_pc <= '0;
        end else if (accept) begin
            out_alusel <= alusel;
            out_asel <= asel;
            out_bsel <= bsel;
            out_imm <= imm;
            out_rs1 <= in_instr[19:15];
            out_rs2 <= in_instr[24:20];
            out_rd <= in_instr[11:7];
            out_regwen <= regwen;
            out_illegal <= ill;
            out_pc <= in_pc;
        end
    end
endmodule
